uart_sample_formatter: RTL

Converts each 12-bit ADC sample plus its 2-bit channel number into an 8-byte ASCII record: channel digit, separator, four decimal digits, CR, LF. It sits directly upstream of the UART transmitter and drives its byte handshake (`tx_data`/`tx_valid`/`tx_ready`). Samples that arrive while a record is still in flight are dropped and counted, never queued. There is no backpressure toward the sampler.

---
 rtl/uart_fmt_pkg.sv | 21 ++
 rtl/uart_sample_formatter_if.sv | 34 +++
 rtl/bin2bcd_12.sv | 65 ++++++
 rtl/uart_sample_formatter.sv | 118 +++++++++++
 4 files changed

// File: rtl/uart_fmt_pkg.sv
// Shared types and constants for the ADC sample to ASCII record formatter.
package uart_fmt_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StSend
    } fmt_state_e;

    localparam int unsigned FRAME_LEN = 8;
    localparam int unsigned BCD_STEPS = 12;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit);
        return ASCII_ZERO + {4'h0, digit};
    endfunction

endpackage

// File: rtl/uart_sample_formatter_if.sv
// Sample strobe and UART byte handshake between sampler, formatter and transmitter.
interface uart_sample_formatter_if;

    logic [11:0] sample_data;
    logic [1:0]  sample_channel;
    logic        sample_valid;
    logic        sample_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    // Environment side: sampler plus UART transmitter.
    modport master (
        output sample_data,
        output sample_channel,
        output sample_valid,
        input  sample_ready,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

    // Formatter side.
    modport slave (
        input  sample_data,
        input  sample_channel,
        input  sample_valid,
        output sample_ready,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

endinterface

// File: rtl/bin2bcd_12.sv
// Iterative double-dabble converter: 12-bit binary to four BCD digits in 12 cycles.
module bin2bcd_12
    import uart_fmt_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] bin,
    input  logic        start,
    output logic [3:0]  thousands,
    output logic [3:0]  hundreds,
    output logic [3:0]  tens,
    output logic [3:0]  ones,
    output logic        done
);

    logic [11:0] bin_q;
    logic [15:0] bcd_q;
    logic [3:0]  step_q;
    logic        busy_q;
    logic        done_q;

    function automatic logic [15:0] add3(input logic [15:0] bcd);
        logic [15:0] res;
        res = bcd;
        for (int i = 0; i < 4; i++) begin
            if (res[i*4 +: 4] >= 4'd5) begin
                res[i*4 +: 4] = res[i*4 +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                bin_q  <= bin;
                bcd_q  <= '0;
                step_q <= '0;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                // Correct every digit that would overflow, then shift one binary bit in.
                {bcd_q, bin_q} <= {add3(bcd_q), bin_q} << 1;
                step_q         <= step_q + 4'd1;
                if (step_q == 4'(BCD_STEPS - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign thousands = bcd_q[15:12];
    assign hundreds  = bcd_q[11:8];
    assign tens      = bcd_q[7:4];
    assign ones      = bcd_q[3:0];
    assign done      = done_q;

endmodule

// File: rtl/uart_sample_formatter.sv
// Formats one ADC sample into an 8-byte ASCII record and feeds it to the UART transmitter.
module uart_sample_formatter
    import uart_fmt_pkg::*;
#(
    parameter int unsigned DROP_CNT_WIDTH = 16,
    parameter logic [7:0]  SEPARATOR      = 8'h2C
) (
    input  logic                      clk,
    input  logic                      reset,
    uart_sample_formatter_if.slave    bus,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
);

    localparam int unsigned IdxWidth = $clog2(FRAME_LEN);

    fmt_state_e                state_q;
    logic [IdxWidth-1:0]       idx_q;
    logic [1:0]                channel_q;
    logic [15:0]               digits_q;
    logic [7:0]                tx_data_q;
    logic                      tx_valid_q;
    logic [DROP_CNT_WIDTH-1:0] drop_q;

    logic        conv_start;
    logic        conv_done;
    logic [3:0]  conv_thousands;
    logic [3:0]  conv_hundreds;
    logic [3:0]  conv_tens;
    logic [3:0]  conv_ones;
    logic [15:0] conv_digits;

    function automatic logic [7:0] record_byte(input logic [IdxWidth-1:0] idx,
                                               input logic [1:0] channel,
                                               input logic [15:0] digits);
        logic [7:0] b;
        case (idx)
            3'd0:    b = ASCII_ZERO + {6'h00, channel};
            3'd1:    b = SEPARATOR;
            3'd2:    b = digit_to_ascii(digits[15:12]);
            3'd3:    b = digit_to_ascii(digits[11:8]);
            3'd4:    b = digit_to_ascii(digits[7:4]);
            3'd5:    b = digit_to_ascii(digits[3:0]);
            3'd6:    b = ASCII_CR;
            default: b = ASCII_LF;
        endcase
        return b;
    endfunction

    // Starting straight from the strobe lets the converter run during the first CONVERT cycle.
    assign conv_start  = bus.sample_valid && (state_q == StIdle);
    assign conv_digits = {conv_thousands, conv_hundreds, conv_tens, conv_ones};

    bin2bcd_12 u_bin2bcd (
        .clk       (clk),
        .reset     (reset),
        .bin       (bus.sample_data),
        .start     (conv_start),
        .thousands (conv_thousands),
        .hundreds  (conv_hundreds),
        .tens      (conv_tens),
        .ones      (conv_ones),
        .done      (conv_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            channel_q  <= '0;
            digits_q   <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            if (bus.sample_valid && (state_q != StIdle) && (drop_q != '1)) begin
                drop_q <= drop_q + 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (bus.sample_valid) begin
                        channel_q <= bus.sample_channel;
                        state_q   <= StConvert;
                    end
                end
                StConvert: begin
                    if (conv_done) begin
                        digits_q   <= conv_digits;
                        idx_q      <= '0;
                        tx_data_q  <= record_byte('0, channel_q, conv_digits);
                        tx_valid_q <= 1'b1;
                        state_q    <= StSend;
                    end
                end
                StSend: begin
                    // tx_valid is always high here, so tx_ready alone marks a transfer.
                    if (bus.tx_ready) begin
                        if (idx_q == IdxWidth'(FRAME_LEN - 1)) begin
                            idx_q      <= '0;
                            tx_valid_q <= 1'b0;
                            state_q    <= StIdle;
                        end else begin
                            idx_q     <= idx_q + 1'b1;
                            tx_data_q <= record_byte(idx_q + 1'b1, channel_q, digits_q);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.sample_ready = (state_q == StIdle);
    assign bus.tx_data      = tx_data_q;
    assign bus.tx_valid     = tx_valid_q;
    assign drop_count       = drop_q;

endmodule
